// File: rtl/seq_det_ctrl.sv
// Frame sequencer and round-robin arbiter for the serial sequence detector.
// Grants one of two requesters, shifts its frame LSB-first onto w, drains, then reports the z-hit count.
module seq_det_ctrl #(
    parameter int FRAME_W   = 8,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [FRAME_W-1:0] data0,
    input  logic [FRAME_W-1:0] data1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               w,
    input  logic               z,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [CNT_W-1:0]   hits
);

    localparam int CW = $clog2(FRAME_W + DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               id_q, id_d;
    logic               last_id_q, last_id_d;
    logic               w_q, w_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic               pick1_s;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
        logic [CNT_W-1:0] res;
        if (en && (val != {CNT_W{1'b1}})) begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sh_q      <= {FRAME_W{1'b0}};
            cnt_q     <= {CW{1'b0}};
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            w_q       <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            hits_q    <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            w_q       <= w_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            hits_q    <= hits_d;
        end
    end

    // Next-state, arbitration, shift and hit-count logic.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        w_d       = 1'b1;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;

        // On a tie the requester not served last wins.
        if (req0 && req1) begin
            pick1_s = ~last_id_q;
        end else begin
            pick1_s = req1;
        end

        if ((state_q == ST_SHIFT) || (state_q == ST_DRAIN)) begin
            hits_d = sat_inc(hits_q, z);
        end else begin
            hits_d = hits_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d   = ST_SHIFT;
                    id_d      = pick1_s;
                    last_id_d = pick1_s;
                    gnt0_d    = ~pick1_s;
                    gnt1_d    = pick1_s;
                    cnt_d     = {CW{1'b0}};
                    hits_d    = {CNT_W{1'b0}};
                    if (pick1_s) begin
                        w_d  = data1[0];
                        sh_d = {1'b0, data1[FRAME_W-1:1]};
                    end else begin
                        w_d  = data0[0];
                        sh_d = {1'b0, data0[FRAME_W-1:1]};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CW'(FRAME_W - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = {CW{1'b0}};
                    w_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    w_d   = sh_q[0];
                    sh_d  = {1'b0, sh_q[FRAME_W-1:1]};
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CW'(DRAIN_CYC - 1)) begin
                    state_d   = ST_REPORT;
                    cnt_d     = {CW{1'b0}};
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign w       = w_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign hits    = hits_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed testbench for seq_det_ctrl: serial order, hit counting, round-robin,
// reset abort, unbalanced load, and counter saturation on a CNT_W=3 instance.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, z;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, w, busy, done, done_id;
    logic [3:0] hits;

    logic       s_req0, s_z;
    logic [7:0] s_data0;
    logic       s_gnt0, s_gnt1, s_w, s_busy, s_done, s_done_id;
    logic [2:0] s_hits;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.FRAME_W(8), .DRAIN_CYC(2), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .w(w), .z(z), .busy(busy), .done(done),
        .done_id(done_id), .hits(hits)
    );

    seq_det_ctrl #(.FRAME_W(8), .DRAIN_CYC(2), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .req0(s_req0), .req1(1'b0), .data0(s_data0), .data1(8'h00),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .w(s_w), .z(s_z), .busy(s_busy), .done(s_done),
        .done_id(s_done_id), .hits(s_hits)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at #1 in an IDLE cycle with requests set; returns at #1 of the done cycle (cycle 11).
    // zp[c] is driven on z during cycle c; drop releases the winner's req after its grant;
    // r0_on raises req0 in that cycle (0 = never).
    task automatic do_frame(input logic exp_id, input logic [7:0] d, input logic [11:0] zp,
                            input logic [3:0] exp_hits, input logic drop, input int r0_on);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            z = zp[c];
            check_eq("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
            if (c == 1) begin
                check_eq("gnt0", {31'd0, gnt0}, {31'd0, ~exp_id});
                check_eq("gnt1", {31'd0, gnt1}, {31'd0, exp_id});
                if (drop && !exp_id) req0 = 1'b0;
                if (drop && exp_id)  req1 = 1'b0;
            end else begin
                check_eq("gnt_idle", {30'd0, gnt0, gnt1}, 32'd0);
            end
            if (c == r0_on) req0 = 1'b1;
            check_eq("busy", {31'd0, busy}, 32'd1);
            if (c <= 8) check_eq("w_bit", {31'd0, w}, {31'd0, d[c-1]});
            else        check_eq("w_pad", {31'd0, w}, 32'd1);
            if (c == 11) begin
                check_eq("done", {31'd0, done}, 32'd1);
                check_eq("done_id", {31'd0, done_id}, {31'd0, exp_id});
                check_eq("hits", {28'd0, hits}, {28'd0, exp_hits});
            end else begin
                check_eq("no_done", {31'd0, done}, 32'd0);
            end
        end
        z = 1'b0;
    endtask

    // Call at #1 of a done cycle: the following cycle must be idle with no grant.
    task automatic idle_gap();
        @(posedge clk); #1;
        check_eq("gap_busy", {31'd0, busy}, 32'd0);
        check_eq("gap_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        check_eq("gap_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; z = 1'b0; data0 = 8'h00; data1 = 8'h00;
        s_req0 = 1'b0; s_z = 1'b0; s_data0 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_w", {31'd0, w}, 32'd1);
        check_eq("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_done_id", {31'd0, done_id}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_hits", {28'd0, hits}, 32'd0);

        // Serial order: A5 goes out 1,0,1,0,0,1,0,1.
        rst_n = 1'b1; data0 = 8'hA5; req0 = 1'b1;
        do_frame(1'b0, 8'hA5, 12'h000, 4'd0, 1'b1, 0);

        // Hit count: z high in cycles 3,4,9 counts; the cycle-11 high must not.
        idle_gap();
        data1 = 8'h3C; req1 = 1'b1;
        do_frame(1'b1, 8'h3C, 12'hA18, 4'd3, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hits_hold", {28'd0, hits}, 32'd3);
        check_eq("hold_busy", {31'd0, busy}, 32'd0);

        // Tie from reset release: 0,1,0,1 with 12-cycle spacing.
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 8'h5A; data1 = 8'hC3;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_frame(1'b0, 8'h5A, 12'h000, 4'd0, 1'b0, 0);
        idle_gap();
        do_frame(1'b1, 8'hC3, 12'h006, 4'd2, 1'b0, 0);
        idle_gap();
        do_frame(1'b0, 8'h5A, 12'h400, 4'd1, 1'b0, 0);
        idle_gap();
        do_frame(1'b1, 8'hC3, 12'h000, 4'd0, 1'b0, 0);
        req0 = 1'b0; req1 = 1'b0;

        // Reset in cycle 4 of a frame aborts it.
        idle_gap();
        data0 = 8'h00; req0 = 1'b1;
        @(posedge clk); #1;
        check_eq("ab_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0; z = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(posedge clk); #1;
        z = 1'b0;
        check_eq("ab_hits_pre", {28'd0, hits}, 32'd3);
        check_eq("ab_w_pre", {31'd0, w}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("ab_w", {31'd0, w}, 32'd1);
        check_eq("ab_busy", {31'd0, busy}, 32'd0);
        check_eq("ab_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        check_eq("ab_hits", {28'd0, hits}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("ab_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1; data1 = 8'h81; req1 = 1'b1;
        do_frame(1'b1, 8'h81, 12'h000, 4'd0, 1'b1, 0);

        // Unbalanced: req1 held, req0 pulsed mid-frame, served next, then back to req1.
        idle_gap();
        data1 = 8'h96; data0 = 8'h0F; req1 = 1'b1;
        do_frame(1'b1, 8'h96, 12'h000, 4'd0, 1'b0, 5);
        idle_gap();
        do_frame(1'b0, 8'h0F, 12'h000, 4'd0, 1'b1, 0);
        idle_gap();
        do_frame(1'b1, 8'h96, 12'h000, 4'd0, 1'b0, 0);
        req1 = 1'b0;

        // Saturation on the CNT_W=3 instance: z held high for the whole frame.
        @(posedge clk); #1;
        s_data0 = 8'h33; s_req0 = 1'b1; s_z = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (s_gnt0) s_req0 = 1'b0;
            if (s_done) break;
        end
        check_eq("sat_done", {31'd0, s_done}, 32'd1);
        check_eq("sat_hits", {29'd0, s_hits}, 32'd7);
        s_z = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
